// File: rtl/adbg_spr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adbg_spr_pkg : shared constants and FSM encoding for adbg_spr_resp   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adbg_spr_pkg;

  localparam logic [15:0] ADDR_CTRL     = 16'h0000;
  localparam logic [15:0] ADDR_STATUS   = 16'h0001;
  localparam logic [15:0] ADDR_NPC      = 16'h0002;
  localparam logic [15:0] ADDR_BP_BASE  = 16'h0010;
  localparam logic [15:0] ADDR_GPR_BASE = 16'h0100;

  localparam int CTRL_HALT   = 0;
  localparam int CTRL_STEP   = 1;
  localparam int CTRL_RESUME = 2;

  localparam int STAT_HALTED = 0;
  localparam int STAT_ERR    = 1;
  localparam int STAT_BP     = 2;

  localparam logic [31:0] ERR_DATA = 32'hBADACCE5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RF_WAIT = 2'd1,
    ACK     = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/adbg_spr_bp_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adbg_spr_bp_unit : NUM_BP PC breakpoint comparators with BP/BPCTRL   |
// | registers at ADDR_BP_BASE + 2n / + 2n + 1.              Rev 1.0      |
// +----------------------------------------------------------------------+
module adbg_spr_bp_unit
  import adbg_spr_pkg::*;
#(
  parameter int NUM_BP = 2
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        wr_i,
  input  logic [31:0] pc_i,
  input  logic        halted_i,
  output logic        sel_o,
  output logic [31:0] rdata_o,
  output logic        hit_o
);

  logic [15:0]       off;
  logic [31:0]       bp_val [NUM_BP];
  logic [NUM_BP-1:0] bp_en;
  logic [NUM_BP-1:0] match_vec;
  logic              match;
  logic              match_q;

  assign off   = addr_i - ADDR_BP_BASE;
  assign sel_o = (addr_i >= ADDR_BP_BASE) && (off < 16'(2 * NUM_BP));
  assign match = (|match_vec) && !halted_i;

  generate
    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
      logic idx_hit;
      assign idx_hit      = sel_o && (off[15:1] == 15'(i));
      assign match_vec[i] = bp_en[i] && (bp_val[i] == pc_i);

      always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
          bp_val[i] <= '0;
          bp_en[i]  <= 1'b0;
        end else if (wr_i && idx_hit) begin
          if (off[0]) bp_en[i]  <= wdata_i[0];
          else        bp_val[i] <= wdata_i;
        end
      end
    end
  endgenerate

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (sel_o && (off[15:1] == 15'(i)))
        rdata_o = off[0] ? {31'b0, bp_en[i]} : bp_val[i];
    end
  end

  // Edge-detect so a PC parked on a breakpoint yields a single hit pulse.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      match_q <= 1'b0;
      hit_o   <= 1'b0;
    end else begin
      match_q <= match;
      hit_o   <= match && !match_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adbg_spr_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adbg_spr_resp : per-core debug SPR responder (CTRL/STATUS/NPC/GPR).  |
// | Breakpoints enabled by ADBG_SPR_RESP_BP_EN.             Rev 1.0      |
// +----------------------------------------------------------------------+
module adbg_spr_resp
  import adbg_spr_pkg::*;
#(
  parameter int NUM_GPR    = 32,
  parameter int RF_TIMEOUT = 15,
  parameter int NUM_BP     = 2
) (
  input  logic                       cpu_clk_i,
  input  logic                       cpu_rst_i,
  input  logic [15:0]                dbg_addr_i,
  input  logic [31:0]                dbg_data_i,
  output logic [31:0]                dbg_data_o,
  input  logic                       dbg_stb_i,
  input  logic                       dbg_we_i,
  output logic                       dbg_ack_o,
  output logic                       halt_req_o,
  output logic                       step_o,
  output logic                       resume_o,
  input  logic                       halted_i,
  input  logic [31:0]                npc_i,
  output logic [31:0]                npc_o,
  output logic                       npc_we_o,
  output logic                       rf_req_o,
  output logic                       rf_we_o,
  output logic [$clog2(NUM_GPR)-1:0] rf_addr_o,
  output logic [31:0]                rf_wdata_o,
  input  logic [31:0]                rf_rdata_i,
  input  logic                       rf_gnt_i,
  input  logic [31:0]                pc_i,
  output logic                       bp_hit_o
);

  localparam int GW = $clog2(NUM_GPR);
  localparam int TW = $clog2(RF_TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          err_q;
  logic          bp_sticky;
  logic [15:0]   gpr_off;
  logic          is_gpr;
  logic [31:0]   csr_rdata;
  logic          bp_sel;
  logic [31:0]   bp_rdata;

  assign gpr_off = dbg_addr_i - ADDR_GPR_BASE;
  assign is_gpr  = (dbg_addr_i >= ADDR_GPR_BASE) && (gpr_off < 16'(NUM_GPR));

`ifdef ADBG_SPR_RESP_BP_EN
  adbg_spr_bp_unit #(
    .NUM_BP (NUM_BP)
  ) u_bp (
    .cpu_clk_i (cpu_clk_i),
    .cpu_rst_i (cpu_rst_i),
    .addr_i    (dbg_addr_i),
    .wdata_i   (dbg_data_i),
    .wr_i      ((state == IDLE) && dbg_stb_i && dbg_we_i),
    .pc_i      (pc_i),
    .halted_i  (halted_i),
    .sel_o     (bp_sel),
    .rdata_o   (bp_rdata),
    .hit_o     (bp_hit_o)
  );
`else
  logic unused_pc;
  assign unused_pc = ^pc_i;
  assign bp_sel    = 1'b0;
  assign bp_rdata  = '0;
  assign bp_hit_o  = 1'b0;
`endif

  always_comb begin
    csr_rdata = '0;
    if (bp_sel) begin
      csr_rdata = bp_rdata;
    end else begin
      case (dbg_addr_i)
        ADDR_CTRL:   csr_rdata[CTRL_HALT] = halt_req_o;
        ADDR_STATUS: begin
          csr_rdata[STAT_HALTED] = halted_i;
          csr_rdata[STAT_ERR]    = err_q;
          csr_rdata[STAT_BP]     = bp_sticky;
        end
        ADDR_NPC:    csr_rdata = npc_i;
        default:     csr_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
      bp_sticky  <= 1'b0;
      dbg_ack_o  <= 1'b0;
      dbg_data_o <= '0;
      halt_req_o <= 1'b0;
      step_o     <= 1'b0;
      resume_o   <= 1'b0;
      npc_o      <= '0;
      npc_we_o   <= 1'b0;
      rf_req_o   <= 1'b0;
      rf_we_o    <= 1'b0;
      rf_addr_o  <= '0;
      rf_wdata_o <= '0;
    end else begin
      step_o     <= 1'b0;
      resume_o   <= 1'b0;
      npc_we_o   <= 1'b0;
      dbg_ack_o  <= 1'b0;
      dbg_data_o <= '0;

      case (state)
        IDLE: begin
          if (dbg_stb_i) begin
            if (is_gpr && halted_i) begin
              rf_req_o   <= 1'b1;
              rf_we_o    <= dbg_we_i;
              rf_addr_o  <= gpr_off[GW-1:0];
              rf_wdata_o <= dbg_data_i;
              tmo_cnt    <= '0;
              state      <= RF_WAIT;
            end else begin
              state      <= ACK;
              dbg_ack_o  <= 1'b1;
              dbg_data_o <= dbg_we_i ? 32'h0 : csr_rdata;
              if (is_gpr) begin
                err_q <= 1'b1;
              end else if (dbg_we_i) begin
                case (dbg_addr_i)
                  ADDR_CTRL: begin
                    // Resume overrides a halt request written in the same word.
                    halt_req_o <= dbg_data_i[CTRL_HALT] && !dbg_data_i[CTRL_RESUME];
                    resume_o   <= dbg_data_i[CTRL_RESUME];
                    step_o     <= dbg_data_i[CTRL_STEP] && halted_i;
                  end
                  ADDR_STATUS: begin
                    err_q     <= 1'b0;
                    bp_sticky <= 1'b0;
                  end
                  ADDR_NPC: begin
                    npc_o    <= dbg_data_i;
                    npc_we_o <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        RF_WAIT: begin
          if (!dbg_stb_i) begin
            rf_req_o <= 1'b0;
            state    <= IDLE;
          end else if (rf_gnt_i) begin
            rf_req_o   <= 1'b0;
            dbg_ack_o  <= 1'b1;
            dbg_data_o <= rf_we_o ? 32'h0 : rf_rdata_i;
            state      <= ACK;
          end else if (tmo_cnt == TW'(RF_TIMEOUT - 1)) begin
            rf_req_o   <= 1'b0;
            dbg_ack_o  <= 1'b1;
            dbg_data_o <= ERR_DATA;
            err_q      <= 1'b1;
            state      <= ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ACK:     state <= HOLD;
        HOLD:    if (!dbg_stb_i) state <= IDLE;
        default: state <= IDLE;
      endcase

`ifdef ADBG_SPR_RESP_BP_EN
      if (bp_hit_o) begin
        halt_req_o <= 1'b1;
        bp_sticky  <= 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adbg_spr_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adbg_spr_resp : directed scoreboard bench for adbg_spr_resp       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_adbg_spr_resp;

  localparam int RF_TIMEOUT = 15;

  logic        cpu_clk_i = 1'b0;
  logic        cpu_rst_i;
  logic [15:0] dbg_addr_i;
  logic [31:0] dbg_data_i;
  logic [31:0] dbg_data_o;
  logic        dbg_stb_i;
  logic        dbg_we_i;
  logic        dbg_ack_o;
  logic        halt_req_o;
  logic        step_o;
  logic        resume_o;
  logic        halted_i;
  logic [31:0] npc_i;
  logic [31:0] npc_o;
  logic        npc_we_o;
  logic        rf_req_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] rf_rdata_i;
  logic        rf_gnt_i;
  logic [31:0] pc_i;
  logic        bp_hit_o;

  adbg_spr_resp dut (
    .cpu_clk_i  (cpu_clk_i),
    .cpu_rst_i  (cpu_rst_i),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_i (dbg_data_i),
    .dbg_data_o (dbg_data_o),
    .dbg_stb_i  (dbg_stb_i),
    .dbg_we_i   (dbg_we_i),
    .dbg_ack_o  (dbg_ack_o),
    .halt_req_o (halt_req_o),
    .step_o     (step_o),
    .resume_o   (resume_o),
    .halted_i   (halted_i),
    .npc_i      (npc_i),
    .npc_o      (npc_o),
    .npc_we_o   (npc_we_o),
    .rf_req_o   (rf_req_o),
    .rf_we_o    (rf_we_o),
    .rf_addr_o  (rf_addr_o),
    .rf_wdata_o (rf_wdata_o),
    .rf_rdata_i (rf_rdata_i),
    .rf_gnt_i   (rf_gnt_i),
    .pc_i       (pc_i),
    .bp_hit_o   (bp_hit_o)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  int vectors = 0, miscompares = 0;
  int ack_cnt = 0, step_cnt = 0, resume_cnt = 0, npc_we_cnt = 0, bp_cnt = 0;
  logic [31:0] exp_q[$];

  int          gnt_delay = -1;
  int          gnt_wait = 0;
  logic        req_seen = 1'b0;
  logic [4:0]  last_rf_addr = '0;
  logic        last_rf_we = 1'b0;
  logic [31:0] last_rf_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and counts core-side pulses.
  always @(negedge cpu_clk_i) begin
    if (!cpu_rst_i) begin
      if (step_o)   step_cnt++;
      if (resume_o) resume_cnt++;
      if (npc_we_o) npc_we_cnt++;
      if (bp_hit_o) bp_cnt++;
      if (dbg_ack_o) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got data 0x%08h with empty scoreboard", dbg_data_o);
        end else begin
          chk("ack_data", dbg_data_o, exp_q.pop_front());
        end
      end
    end
  end

  // Register-file responder: grants gnt_delay cycles after rf_req_o rises (-1 = never).
  initial begin
    rf_gnt_i   = 1'b0;
    rf_rdata_i = 32'h12345678;
    forever begin
      @(posedge cpu_clk_i); #1;
      if (rf_req_o && !rf_gnt_i) begin
        req_seen      = 1'b1;
        last_rf_addr  = rf_addr_o;
        last_rf_we    = rf_we_o;
        last_rf_wdata = rf_wdata_o;
        if (gnt_delay >= 0) begin
          if (gnt_wait == gnt_delay) rf_gnt_i = 1'b1;
          else gnt_wait++;
        end
      end else begin
        rf_gnt_i = 1'b0;
        gnt_wait = 0;
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge cpu_clk_i); #1;
    end
  endtask

  task automatic xact(input string name, input logic [15:0] a, input logic w,
                      input logic [31:0] d, input logic [31:0] exp, input int exp_lat,
                      input int hold_extra);
    int lat;
    bit got;
    exp_q.push_back(exp);
    dbg_addr_i = a; dbg_we_i = w; dbg_data_i = d; dbg_stb_i = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge cpu_clk_i); #1;
      lat++;
      if (dbg_ack_o) got = 1;
    end
    if (!got) begin
      chk({name, "_ack_timeout"}, 32'(lat), 32'(exp_lat));
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      @(posedge cpu_clk_i); #1;
      chk({name, "_ack_width"}, {31'b0, dbg_ack_o}, 32'h0);
    end
    cyc(hold_extra);
    dbg_stb_i = 1'b0;
    cyc(1);
  endtask

  initial begin
    int acks_before;
    cpu_rst_i = 1'b1;
    dbg_addr_i = '0; dbg_data_i = '0; dbg_stb_i = 1'b0; dbg_we_i = 1'b0;
    halted_i = 1'b0; npc_i = '0; pc_i = '0;
    cyc(3);
    chk("rst_ack", {31'b0, dbg_ack_o}, 32'h0);
    chk("rst_data", dbg_data_o, 32'h0);
    chk("rst_halt", {31'b0, halt_req_o}, 32'h0);
    chk("rst_rfreq", {31'b0, rf_req_o}, 32'h0);
    chk("rst_pulses", {28'b0, step_o, resume_o, npc_we_o, bp_hit_o}, 32'h0);
    cpu_rst_i = 1'b0;
    cyc(1);

    xact("ctrl_halt", 16'h0000, 1'b1, 32'h1, 32'h0, 1, 0);
    chk("halt_req_set", {31'b0, halt_req_o}, 32'h1);
    halted_i = 1'b1;
    xact("status_rd", 16'h0001, 1'b0, 32'h0, 32'h1, 1, 0);
    xact("ctrl_rd", 16'h0000, 1'b0, 32'h0, 32'h1, 1, 0);

    gnt_delay = 3;
    xact("gpr_rd", 16'h0105, 1'b0, 32'h0, 32'h12345678, 5, 0);
    chk("gpr_rd_addr", {27'b0, last_rf_addr}, 32'd5);
    chk("gpr_rd_we", {31'b0, last_rf_we}, 32'h0);
    gnt_delay = 0;
    xact("gpr_wr", 16'h010A, 1'b1, 32'hCAFEF00D, 32'h0, 2, 0);
    chk("gpr_wr_addr", {27'b0, last_rf_addr}, 32'd10);
    chk("gpr_wr_we", {31'b0, last_rf_we}, 32'h1);
    chk("gpr_wr_data", last_rf_wdata, 32'hCAFEF00D);
    xact("status_noerr", 16'h0001, 1'b0, 32'h0, 32'h1, 1, 0);

    gnt_delay = -1;
    xact("gpr_tmo", 16'h0101, 1'b1, 32'h55AA55AA, 32'hBADACCE5, RF_TIMEOUT + 1, 0);
    xact("status_err", 16'h0001, 1'b0, 32'h0, 32'h3, 1, 0);
    xact("status_clr", 16'h0001, 1'b1, 32'h0, 32'h0, 1, 0);
    xact("status_clrd", 16'h0001, 1'b0, 32'h0, 32'h1, 1, 0);

    npc_i = 32'hDEADBEEF;
    xact("npc_rd", 16'h0002, 1'b0, 32'h0, 32'hDEADBEEF, 1, 0);
    xact("npc_wr", 16'h0002, 1'b1, 32'h00001000, 32'h0, 1, 0);
    chk("npc_o", npc_o, 32'h00001000);
    chk("npc_we_cnt", 32'(npc_we_cnt), 32'd1);

    xact("ctrl_step", 16'h0000, 1'b1, 32'h3, 32'h0, 1, 0);
    chk("step_cnt", 32'(step_cnt), 32'd1);
    chk("halt_after_step", {31'b0, halt_req_o}, 32'h1);

    acks_before = ack_cnt;
    xact("ctrl_resume", 16'h0000, 1'b1, 32'h5, 32'h0, 1, 4);
    chk("resume_single_ack", 32'(ack_cnt - acks_before), 32'd1);
    chk("resume_cnt", 32'(resume_cnt), 32'd1);
    chk("halt_after_resume", {31'b0, halt_req_o}, 32'h0);

    xact("unmapped_rd", 16'h7FFF, 1'b0, 32'h0, 32'h0, 1, 0);

    halted_i = 1'b0;
    req_seen = 1'b0;
    xact("gpr_running", 16'h0103, 1'b0, 32'h0, 32'h0, 1, 0);
    chk("gpr_running_noreq", {31'b0, req_seen}, 32'h0);
    xact("status_run_err", 16'h0001, 1'b0, 32'h0, 32'h2, 1, 0);
    xact("step_running", 16'h0000, 1'b1, 32'h2, 32'h0, 1, 0);
    chk("step_cnt_running", 32'(step_cnt), 32'd1);

    // Strobe withdrawn while waiting for the register file: no ack.
    halted_i = 1'b1;
    gnt_delay = -1;
    acks_before = ack_cnt;
    dbg_addr_i = 16'h0104; dbg_we_i = 1'b0; dbg_stb_i = 1'b1;
    cyc(3);
    chk("abort_req_active", {31'b0, rf_req_o}, 32'h1);
    dbg_stb_i = 1'b0;
    cyc(2);
    chk("abort_req_dropped", {31'b0, rf_req_o}, 32'h0);
    chk("abort_no_ack", 32'(ack_cnt - acks_before), 32'd0);

    halted_i = 1'b0;
    xact("status_clr2", 16'h0001, 1'b1, 32'h0, 32'h0, 1, 0);
    xact("bp0_wr", 16'h0010, 1'b1, 32'h00000100, 32'h0, 1, 0);
    xact("bpctrl0_wr", 16'h0011, 1'b1, 32'h1, 32'h0, 1, 0);
`ifdef ADBG_SPR_RESP_BP_EN
    xact("bp0_rd", 16'h0010, 1'b0, 32'h0, 32'h00000100, 1, 0);
    xact("bpctrl0_rd", 16'h0011, 1'b0, 32'h0, 32'h1, 1, 0);
    pc_i = 32'h00000100;
    cyc(4);
    chk("bp_hit_cnt", 32'(bp_cnt), 32'd1);
    chk("bp_halt_req", {31'b0, halt_req_o}, 32'h1);
    xact("bp_status", 16'h0001, 1'b0, 32'h0, 32'h4, 1, 0);
`else
    xact("bp0_rd", 16'h0010, 1'b0, 32'h0, 32'h0, 1, 0);
    xact("bpctrl0_rd", 16'h0011, 1'b0, 32'h0, 32'h0, 1, 0);
    pc_i = 32'h00000100;
    cyc(4);
    chk("bp_hit_cnt", 32'(bp_cnt), 32'd0);
    chk("bp_halt_req", {31'b0, halt_req_o}, 32'h0);
    xact("bp_status", 16'h0001, 1'b0, 32'h0, 32'h0, 1, 0);
`endif

    cyc(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/adbg_spr_resp.md
Name: adbg_spr_resp

Overview:
- Per-core debug SPR bus responder: the core-side target of the debug bridge's SPR initiator (16-bit addr, 32-bit data, stb/we/ack).
- Holds debug control/status, NPC access and a GPR access path into the core register file, and drives halt/step/resume towards the core pipeline.
- One instance per core, in the core clock domain.

Parameters:
- NUM_GPR, 32, number of GPRs reachable; GPR index width is $clog2(NUM_GPR).
- RF_TIMEOUT, 15, maximum cycles to wait for rf_gnt_i before the access is aborted.
- NUM_BP, 2, number of breakpoint comparators (used only with the optional feature).

Ports:
- cpu_clk_i  in  1  core clock.
- cpu_rst_i  in  1  synchronous, active-high reset.
- dbg_addr_i  in  16  SPR address.
- dbg_data_i  in  32  write data.
- dbg_data_o  out  32  read data, valid while dbg_ack_o=1.
- dbg_stb_i  in  1  request; held until ack.
- dbg_we_i  in  1  1=write, 0=read.
- dbg_ack_o  out  1  one-cycle completion pulse.
- halt_req_o  out  1  level; requests the core to stall.
- step_o  out  1  one-cycle single-step pulse.
- resume_o  out  1  one-cycle resume pulse.
- halted_i  in  1  core is halted.
- npc_i  in  32  core next PC.
- npc_o  out  32  NPC write value.
- npc_we_o  out  1  one-cycle NPC write strobe.
- rf_req_o  out  1  register-file access request.
- rf_we_o  out  1  register-file write.
- rf_addr_o  out  $clog2(NUM_GPR)  GPR index.
- rf_wdata_o  out  32  GPR write data.
- rf_rdata_i  in  32  GPR read data, valid with rf_gnt_i.
- rf_gnt_i  in  1  register-file grant.
- pc_i  in  32  current PC (breakpoint compare).
- bp_hit_o  out  1  breakpoint hit pulse.

Behaviour:
- Reset: all outputs 0; CTRL=0; STATUS.err=0; FSM in IDLE.
- Register map (decoded on dbg_addr_i):
  - 0x0000 CTRL: bit0 halt_req (RW); bit1 step (W1P, pulses step_o only if halted_i); bit2 resume (W1P, clears bit0, pulses resume_o).
  - 0x0001 STATUS (RO): bit0 halted_i; bit1 err (sticky, cleared by any write to STATUS).
  - 0x0002 NPC: read returns npc_i; write drives npc_o and pulses npc_we_o.
  - 0x0100 + n, n < NUM_GPR: GPR n.
  - All other addresses: reads return 0, writes are ignored, ack is still given.
- FSM states and transitions:
  - IDLE: on stb, latch addr/data/we. GPR address with halted_i=1 → RF_WAIT. Anything else → ACK (CSR side effects applied in this cycle).
  - RF_WAIT: rf_req_o=1 with rf_we_o/rf_addr_o/rf_wdata_o held stable. rf_gnt_i → ACK, latching rf_rdata_i. Timeout counter reaching RF_TIMEOUT → ACK with data 0xBADACCE5 and err set.
  - ACK: dbg_ack_o=1 for exactly one cycle, dbg_data_o valid → HOLD.
  - HOLD: wait for dbg_stb_i=0 → IDLE. This prevents retriggering on a stale strobe.
- Latency: CSR access acks 1 cycle after stb; GPR access acks 2 + grant-wait cycles after stb.
- GPR access with halted_i=0: no rf_req_o; reads return 0 and writes are dropped; err is set; ack after 1 cycle.
- stb drops in RF_WAIT: drop rf_req_o and go to IDLE without ack. A write already granted is not undone.
- dbg_data_o is 0 whenever dbg_ack_o=0.
- Simultaneous resume and halt_req=1 in one CTRL write: resume wins, so bit0 ends at 0.
- Reset mid-access: the transaction is lost, no ack is given, all pulses are cleared.

Optional Feature:
- Macro: ADBG_SPR_RESP_BP_EN.
- Defined:
  - BPn address at 0x0010 + 2n, BPCTRLn at 0x0011 + 2n; BPCTRLn bit0 = enable.
  - Enabled match of pc_i == BPn while not halted: pulse bp_hit_o, set halt_req, set sticky STATUS bit2.
- Undefined: those addresses read 0 and ignore writes; bp_hit_o is tied 0; STATUS bit2 reads 0.

Decomposition:
- Package adbg_spr_pkg: address constants (ADDR_CTRL, ADDR_STATUS, ADDR_NPC, ADDR_GPR_BASE, ADDR_BP_BASE), CTRL/STATUS bit indices, the FSM state enum, and the constant ERR_DATA=32'hBADACCE5.
- Sub-module adbg_spr_bp_unit: NUM_BP comparators plus their registers, instantiated only under the macro.

Test Plan:
- CSR: write CTRL=0x1 → halt_req_o=1 and ack 1 cycle after stb; then read STATUS with halted_i=1 → data 0x1.
- GPR read while halted: read 0x0105, rf_gnt_i after 3 cycles with rf_rdata_i=0x12345678 → rf_addr_o=5, ack returns 0x12345678, ack high exactly 1 cycle.
- Timeout: GPR write while halted, rf_gnt_i never asserted → ack after RF_TIMEOUT cycles in RF_WAIT, data 0xBADACCE5, STATUS.err=1.
- Write CTRL=0x5 with halt_req already 1 → resume_o pulses once, halt_req_o=0; a held stb after ack produces no second ack.
- Read 0x7FFF → ack with data 0. A GPR access with halted_i=0 → no rf_req_o and err=1.
- With ADBG_SPR_RESP_BP_EN: BP0=0x100, BPCTRL0=1, pc_i=0x100 → bp_hit_o pulses, halt_req_o=1, STATUS bit2=1.
